z80_stack_xfer_seq: RTL

//  Parametrised stack-transfer sequencer: runs a full PUSH or POP of a DATA_BYTES-wide value

---
 rtl/z80_stack_xfer_seq.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/z80_stack_xfer_seq.sv
// z80_stack_xfer_seq: moves a DATA_BYTES-wide value between the core and SP-relative memory.
// The transfer is either a PUSH (high byte first, below SP) or a POP (low byte first, from SP).
// Exactly one byte moves per bus handshake, and the result is reported with a one-cycle done pulse.
// Optional build macro Z80FI_TRACE_EN adds the trace_mcyc and trace_wait counters.
module z80_stack_xfer_seq #(
    parameter int DATA_BYTES = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    is_push,
    input  logic [15:0]             sp_in,
    input  logic [8*DATA_BYTES-1:0] push_data,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             sp_out,
    output logic [8*DATA_BYTES-1:0] pop_data,
    output logic                    mem_req,
    output logic                    mem_wr,
    output logic [15:0]             mem_addr,
    output logic [7:0]              mem_wdata,
    input  logic [7:0]              mem_rdata,
    input  logic                    mem_ack
`ifdef Z80FI_TRACE_EN
    ,
    output logic [2:0]              trace_mcyc,
    output logic [7:0]              trace_wait
`endif
);

    localparam int DW = 8 * DATA_BYTES;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      idx_q, idx_d;          // byte index k within the transfer
    logic            is_push_q, is_push_d;
    logic [15:0]     sp_q, sp_d;            // SP captured at start
    logic [DW-1:0]   wbuf_q, wbuf_d;        // value being pushed
    logic [DW-1:0]   rbuf_q, rbuf_d;        // bytes collected so far by a POP
    logic [DW-1:0]   pop_data_q, pop_data_d;
    logic [15:0]     sp_out_q, sp_out_d;
    logic            done_q, done_d;
`ifdef Z80FI_TRACE_EN
    logic [2:0]      mcyc_q, mcyc_d;
    logic [7:0]      wait_q, wait_d;
`endif

    logic            last_byte;
    logic [7:0]      wbyte;

    assign last_byte = (idx_q == 2'(DATA_BYTES - 1));

    // Select the byte a PUSH presents for index k: push_data byte DATA_BYTES-1-k.
    always_comb begin
        wbyte = 8'h00;
        for (int b = 0; b < DATA_BYTES; b++) begin
            if (2'(DATA_BYTES - 1 - b) == idx_q) begin
                wbyte = wbuf_q[8*b +: 8];
            end
        end
    end

    // Bus and status outputs, all decoded from registered state so they hold steady during waits.
    always_comb begin
        mem_req   = (state_q == ST_XFER);
        mem_wr    = mem_req && is_push_q;
        mem_addr  = is_push_q ? (sp_q - 16'd1 - {14'd0, idx_q}) : (sp_q + {14'd0, idx_q});
        mem_wdata = wbyte;
        busy      = (state_q != ST_IDLE);
        done      = done_q;
        sp_out    = sp_out_q;
        pop_data  = pop_data_q;
`ifdef Z80FI_TRACE_EN
        trace_mcyc = mcyc_q;
        trace_wait = wait_q;
`endif
    end

    // Next-state logic: accept start in IDLE, step one byte per ack in XFER, publish results from FIN.
    always_comb begin
        // NOTE: every _d gets its hold value first, so paths that leave it untouched cannot infer a latch.
        state_d    = state_q;
        idx_d      = idx_q;
        is_push_d  = is_push_q;
        sp_d       = sp_q;
        wbuf_d     = wbuf_q;
        rbuf_d     = rbuf_q;
        pop_data_d = pop_data_q;
        sp_out_d   = sp_out_q;
        done_d     = 1'b0;
`ifdef Z80FI_TRACE_EN
        mcyc_d     = mcyc_q;
        wait_d     = wait_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_XFER;
                    idx_d     = 2'd0;
                    is_push_d = is_push;
                    sp_d      = sp_in;
                    wbuf_d    = push_data;
                    rbuf_d    = '0;
`ifdef Z80FI_TRACE_EN
                    mcyc_d    = 3'd0;
                    wait_d    = 8'd0;
`endif
                end
            end
            ST_XFER: begin
                if (mem_ack) begin
                    if (!is_push_q) begin
                        for (int b = 0; b < DATA_BYTES; b++) begin
                            if (2'(b) == idx_q) begin
                                rbuf_d[8*b +: 8] = mem_rdata;
                            end
                        end
                    end
`ifdef Z80FI_TRACE_EN
                    mcyc_d = mcyc_q + 3'd1;
`endif
                    if (last_byte) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
`ifdef Z80FI_TRACE_EN
                    if (wait_q != 8'hFF) begin
                        wait_d = wait_q + 8'd1;
                    end
`endif
                end
            end
            ST_FIN: begin
                state_d  = ST_IDLE;
                done_d   = 1'b1;
                sp_out_d = is_push_q ? (sp_q - 16'(DATA_BYTES)) : (sp_q + 16'(DATA_BYTES));
                // A PUSH leaves the last popped value in place.
                if (!is_push_q) begin
                    pop_data_d = rbuf_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset; reset drops any half-finished transfer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= 2'd0;
            is_push_q  <= 1'b0;
            sp_q       <= 16'h0000;
            wbuf_q     <= '0;
            rbuf_q     <= '0;
            pop_data_q <= '0;
            sp_out_q   <= 16'h0000;
            done_q     <= 1'b0;
`ifdef Z80FI_TRACE_EN
            mcyc_q     <= 3'd0;
            wait_q     <= 8'd0;
`endif
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values computed above.
            state_q    <= state_d;
            idx_q      <= idx_d;
            is_push_q  <= is_push_d;
            sp_q       <= sp_d;
            wbuf_q     <= wbuf_d;
            rbuf_q     <= rbuf_d;
            pop_data_q <= pop_data_d;
            sp_out_q   <= sp_out_d;
            done_q     <= done_d;
`ifdef Z80FI_TRACE_EN
            mcyc_q     <= mcyc_d;
            wait_q     <= wait_d;
`endif
        end
    end

endmodule
